// File: rtl/cpu_pkg.sv
// Package shared by the program loader and the processor controller.
// Holds the opcode encodings and the loader state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// loader_word_assembler: collects the high and low byte of an instruction word.
// Optional feature macro: PROGRAM_LOADER_OPCODE_CHECK_EN -- when defined, words whose
// opcode is above OP_HALT are flagged illegal and replaced by a NOOP word.
module loader_word_assembler
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_hi,
  input  logic        load_lo,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        illegal
);

  logic [7:0]  hi_q;
  logic [7:0]  lo_q;
  logic [15:0] raw;

  // Capture each byte on its strobe; the word stays stable through WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 8'h00;
      lo_q <= 8'h00;
    end else begin
      if (load_hi) hi_q <= byte_in;
      if (load_lo) lo_q <= byte_in;
    end
  end

  assign raw = {hi_q, lo_q};

`ifdef PROGRAM_LOADER_OPCODE_CHECK_EN
  // Opcodes beyond HALT are not executable; substitute a NOOP word.
  always_comb begin
    illegal = (raw[15:12] > OP_HALT);
    word    = illegal ? {OP_NOOP, 12'h000} : raw;
  end
`else
  // Words pass through unchanged.
  always_comb begin
    illegal = 1'b0;
    word    = raw;
  end
`endif

endmodule

// File: rtl/program_loader.sv
// program_loader: writer side of the instruction memory. Takes a byte stream
// (count byte N, then N words high byte first), writes words at addresses 0..N-1,
// and holds the processor in reset until the load is complete.
// Optional feature macro: PROGRAM_LOADER_OPCODE_CHECK_EN (opcode check in the assembler).
//
// state | meaning
// IDLE  | after reset, waiting for start
// COUNT | accept word-count byte N
// HI    | accept high byte of the next word
// LO    | accept low byte of the next word
// WRITE | one-cycle memory write of the assembled word
// DONE  | load complete, processor running, waiting for start
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] IM_addr,
  output logic [15:0]       IM_data,
  output logic              IM_wr,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  loader_state_t    state;
  loader_state_t    next_state;
  logic [CNT_W-1:0] remaining;
  logic             load_hi;
  logic             load_lo;
  logic             word_illegal;
  logic             too_big;
  logic             start_ok;

  assign too_big  = ({1'b0, byte_in[CNT_W-1:0]} > DEPTH_L);
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  loader_word_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .load_hi (load_hi),
    .load_lo (load_lo),
    .byte_in (byte_in),
    .word    (IM_data),
    .illegal (word_illegal)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic, handshake ready, byte strobes and write enable.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    IM_wr      = 1'b0;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    case (state)
      IDLE: if (start) next_state = COUNT;
      COUNT: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (byte_in == 8'h00 || too_big) next_state = DONE;
          else                             next_state = HI;
        end
      end
      HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          load_hi    = 1'b1;
          next_state = LO;
        end
      end
      LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          load_lo    = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        IM_wr      = 1'b1;
        next_state = (remaining == CNT_W'(1)) ? DONE : HI;
      end
      DONE:    if (start) next_state = COUNT;
      default: next_state = IDLE;
    endcase
  end

  // Address/count datapath and status flags; cpu_run goes high one cycle after
  // entering DONE and drops on the same edge that a new session starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IM_addr   <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cpu_run   <= 1'b0;
    end else begin
      busy    <= (next_state != IDLE) && (next_state != DONE);
      cpu_run <= (state == DONE) && (next_state == DONE);
      if (start_ok) begin
        err     <= 1'b0;
        IM_addr <= '0;
      end
      if (state == COUNT && byte_valid) begin
        remaining <= byte_in[CNT_W-1:0];
        if (too_big) err <= 1'b1;
      end
      if (state == WRITE) begin
        IM_addr   <= IM_addr + 1'b1;
        remaining <= remaining - 1'b1;
        if (word_illegal) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader with hand-computed expectations.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [6:0]  IM_addr;
  logic [15:0] IM_data;
  logic        IM_wr;
  logic        cpu_run;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;
  int rdy_in_wr = 0;
  logic [6:0]  wa[$];
  logic [15:0] wd[$];

  program_loader #(.ADDR_W(7), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .IM_addr    (IM_addr),
    .IM_data    (IM_data),
    .IM_wr      (IM_wr),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Record every memory write and any ready-during-write overlap.
  always @(negedge clk) begin
    if (IM_wr) begin
      wa.push_back(IM_addr);
      wd.push_back(IM_data);
      if (byte_ready) rdy_in_wr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte until accepted; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (byte_ready) done = 1;
      tick();
    end
    byte_valid = 1'b0;
    byte_in    = 8'hEE;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_run();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cpu_run) done = 1;
      else tick();
    end
    chk("run_wait", {31'd0, cpu_run}, 1);
  endtask

  initial begin
    // 1. reset and quiet idle
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_addr", {25'd0, IM_addr}, 0);
    chk("rst_data", {16'd0, IM_data}, 0);
    chk("rst_wr", {31'd0, IM_wr}, 0);
    chk("rst_ready", {31'd0, byte_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_run", {31'd0, cpu_run}, 0);
    byte_valid = 1'b1; byte_in = 8'h05;
    repeat (5) tick();
    byte_valid = 1'b0;
    chk("idle_ready", {31'd0, byte_ready}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_writes", wa.size(), 0);

    // 2. two-word load with latency checks
    pulse_start();
    chk("t2_busy", {31'd0, busy}, 1);
    chk("t2_ready", {31'd0, byte_ready}, 1);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h29);
    chk("t2_wr0", {31'd0, IM_wr}, 1);
    chk("t2_addr0", {25'd0, IM_addr}, 0);
    chk("t2_data0", {16'd0, IM_data}, 32'h1029);
    chk("t2_rdy_wr", {31'd0, byte_ready}, 0);
    send_byte(8'h30);
    send_byte(8'h12);
    chk("t2_addr1", {25'd0, IM_addr}, 1);
    chk("t2_data1", {16'd0, IM_data}, 32'h3012);
    tick();
    chk("t2_addr_inc", {25'd0, IM_addr}, 2);
    chk("t2_busy_done", {31'd0, busy}, 0);
    chk("t2_run_early", {31'd0, cpu_run}, 0);
    tick();
    chk("t2_run", {31'd0, cpu_run}, 1);
    chk("t2_err", {31'd0, err}, 0);
    chk("t2_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("t2_q_a0", {25'd0, wa[0]}, 0);
      chk("t2_q_d0", {16'd0, wd[0]}, 32'h1029);
      chk("t2_q_a1", {25'd0, wa[1]}, 1);
      chk("t2_q_d1", {16'd0, wd[1]}, 32'h3012);
    end
    wa.delete(); wd.delete();

    // 3. N=0 and N=129
    pulse_start();
    chk("t3_run_drop", {31'd0, cpu_run}, 0);
    chk("t3_busy", {31'd0, busy}, 1);
    chk("t3_addr_clr", {25'd0, IM_addr}, 0);
    send_byte(8'h00);
    chk("t3_busy0", {31'd0, busy}, 0);
    chk("t3_run0_early", {31'd0, cpu_run}, 0);
    tick();
    chk("t3_run0", {31'd0, cpu_run}, 1);
    pulse_start();
    send_byte(8'h81);
    chk("t3_err", {31'd0, err}, 1);
    chk("t3_busy_e", {31'd0, busy}, 0);
    tick();
    chk("t3_run_e", {31'd0, cpu_run}, 1);
    chk("t3_nwr", wa.size(), 0);

    // 4. toggled valid, mid-session start ignored
    pulse_start();
    chk("t4_err_clr", {31'd0, err}, 0);
    byte_valid = 1'b0; byte_in = 8'hFF; tick();
    send_byte(8'h01);
    start = 1'b1; byte_valid = 1'b0; byte_in = 8'hFF; tick();
    start = 1'b0;
    chk("t4_stall_rdy", {31'd0, byte_ready}, 1);
    chk("t4_stall_busy", {31'd0, busy}, 1);
    send_byte(8'h50);
    byte_valid = 1'b0; byte_in = 8'hFF; tick();
    send_byte(8'h00);
    wait_run();
    chk("t4_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t4_a", {25'd0, wa[0]}, 0);
      chk("t4_d", {16'd0, wd[0]}, 32'h5000);
    end
    chk("t4_addr_end", {25'd0, IM_addr}, 1);
    wa.delete(); wd.delete();

    // 5. opcode above HALT
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h7A);
    send_byte(8'hBC);
    wait_run();
`ifdef PROGRAM_LOADER_OPCODE_CHECK_EN
    chk("t5_err", {31'd0, err}, 1);
    if (wd.size() == 1) chk("t5_d", {16'd0, wd[0]}, 32'h0000);
`else
    chk("t5_err", {31'd0, err}, 0);
    if (wd.size() == 1) chk("t5_d", {16'd0, wd[0]}, 32'h7ABC);
`endif
    chk("t5_nwr", wa.size(), 1);
    wa.delete(); wd.delete();

    // 6a. reset during N=3 after the first word
    pulse_start();
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'h55);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_rst_run", {31'd0, cpu_run}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_rdy", {31'd0, byte_ready}, 0);
    chk("t6_rst_addr", {25'd0, IM_addr}, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_nwr", wa.size(), 1);
    if (wa.size() == 1) chk("t6_d", {16'd0, wd[0]}, 32'h55AA ^ 32'h0000 ^ 32'hFFFF ^ 32'hFFFF ^ 32'h55AA ^ 32'hAA55);
    chk("t6_run_after", {31'd0, cpu_run}, 0);
    wa.delete(); wd.delete();

    // 6b. full-depth load with address wrap
    pulse_start();
    send_byte(8'h80);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      send_byte(iv ^ 8'h30);
      send_byte(~iv);
    end
    wait_run();
    chk("t6_full_nwr", wa.size(), 128);
    if (wa.size() == 128) begin
      chk("t6_full_a0", {25'd0, wa[0]}, 0);
      chk("t6_full_a127", {25'd0, wa[127]}, 32'h7F);
      chk("t6_full_d127", {16'd0, wd[127]}, 32'h4F80);
      chk("t6_full_d5", {16'd0, wd[5]}, 32'h35FA);
    end
    chk("t6_full_wrap", {25'd0, IM_addr}, 0);
    chk("t6_full_err", {31'd0, err}, 0);
    chk("t6_full_busy", {31'd0, busy}, 0);
    chk("rdy_in_write", rdy_in_wr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
